tdec_wrap_out_packer: RTL and testbench
=======================================

Name: tdec_wrap_out_packer

Overview:
Drain-side consumer of the turbo-decoder wrapper byte FIFO. It pops 8-bit decoded bytes for one code block of programmed length and packs them into 32-bit words for the downstream bus. Output uses a valid/ready handshake and marks the last word of the block. On abort it discards the partial word and pulses a flush to the FIFO.

Parameters:
OUT_BYTES, 4, bytes per output word; out_data width = 8*OUT_BYTES.
LEN_W, 16, width of frame_len and the internal remaining-byte counter.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; begins one block; sampled only in IDLE
frame_len  input  LEN_W  block length in bytes; sampled with start
abort  input  1  cancel the current block; highest priority
fifo_empty  input  1  FIFO empty flag
fifo_rd_data  input  8  FIFO head byte, combinational; valid while fifo_empty=0
fifo_rd_en  output  1  FIFO pop; asserted only when fifo_empty=0
fifo_flush  output  1  one-cycle pulse to clear FIFO pointers
out_valid  output  1  out_data/out_last valid
out_data  output  8*OUT_BYTES  packed word
out_last  output  1  final word of the block
out_ready  input  1  downstream accept
busy  output  1  high in FILL and PRESENT
done  output  1  one-cycle pulse at block completion

Behaviour:
- Reset: state=IDLE. fifo_rd_en=0, fifo_flush=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Lane counter=0, remaining=0.
- Lane order: the first byte of a word goes to out_data[7:0], the next to [15:8], and so on. Unfilled lanes are 0.
- IDLE:
  - start with frame_len!=0: latch remaining=frame_len, clear lanes, go to FILL.
  - start with frame_len==0: done pulses the next cycle, no words are output, and the state stays IDLE.
- FILL:
  - fifo_rd_en = !fifo_empty && remaining!=0 && lane<OUT_BYTES. This is combinational, so a byte is popped and captured in the same cycle.
  - Each pop: write fifo_rd_data into lane[lane], lane+1, remaining-1.
  - Go to PRESENT in the cycle after the pop that makes lane==OUT_BYTES or remaining==0. out_last=1 when remaining==0.
  - FIFO empty: wait with no timeout and no pops.
- PRESENT:
  - out_valid=1. out_data and out_last are held stable until out_ready.
  - No pops occur while waiting.
  - Handshake (out_valid&&out_ready) with out_last=0: clear lanes, lane=0, go to FILL.
  - Handshake with out_last=1: go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. out_valid=0.
- Throughput: a full word takes OUT_BYTES fill cycles plus at least 1 present cycle.
- Abort, in any non-IDLE state:
  - Next cycle: IDLE, out_valid=0, lanes cleared, fifo_flush=1 for one cycle, no done.
  - fifo_rd_en is forced 0 in the abort cycle.
  - Abort in IDLE pulses fifo_flush only.
  - Abort together with start: the abort wins and start is ignored.
  - Abort together with a handshake: the word counts as accepted downstream, but the block still ends without done.
- start while busy is ignored; frame_len is not resampled.
- Reset mid-block returns all state to reset values immediately.
- remaining counts down to 0 exactly, with no wrap. frame_len is at most 2^LEN_W-1.

Optional Feature:
TDEC_WRAP_PACKER_BSWAP_EN:
- Defined: byte order is reversed. The first byte of a word goes to the MSB lane, out_data[8*OUT_BYTES-1 -: 8]. Padding on a short last word fills the low lanes with 0.
- Undefined: LSB-first order as specified above.

Decomposition:
- The shared defines header holds the state encodings (IDLE, FILL, PRESENT, DONE) and the default OUT_BYTES/LEN_W values, next to the existing wrap FIFO depth/threshold defines.
- One sub-module is natural: tdec_wrap_lane_asm. It is the byte-to-word lane register with a lane counter, clear, write-enable and BSWAP handling.
- The FSM, the remaining counter and the handshake stay in the top module.

Test Plan:
- frame_len=8, FIFO preloaded 01..08, out_ready=1 → two words: 0x04030201 (last=0), then 0x08070605 (last=1). done pulses once; exactly 8 pops.
- frame_len=5, bytes AA BB CC DD EE → 0xDDCCBBAA, then 0x000000EE with last=1. Under BSWAP_EN: 0xAABBCCDD, then 0xEE000000.
- frame_len=4, out_ready held 0 for 10 cycles → out_valid stays 1 and out_data stays stable. fifo_rd_en stays 0 despite the FIFO being non-empty. On ready, the word is accepted and done pulses.
- fifo_empty toggles every other cycle, frame_len=6 → correct words 0x..., last word padded. Pops occur only when fifo_empty=0.
- Abort mid-FILL after 2 bytes → out_valid never asserts, fifo_flush pulses once, no done. A new start with frame_len=4 then works normally.
- start with frame_len=0 → done the next cycle, no out_valid, no pops. A second start while busy is ignored.

Source files
------------

// File: rtl/tdec_wrap_out_packer_pkg.sv
// tdec_wrap_out_packer_pkg: shared wrap FIFO and output packer definitions
package tdec_wrap_out_packer_pkg;
    localparam int WRAP_FIFO_DEPTH     = 64;
    localparam int WRAP_FIFO_AFULL_THR = 56;
    localparam int DEF_OUT_BYTES       = 4;
    localparam int DEF_LEN_W           = 16;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } pack_state_t;
endpackage

// File: rtl/tdec_wrap_lane_asm.sv
// tdec_wrap_lane_asm: byte-to-word lane register with lane counter; TDEC_WRAP_PACKER_BSWAP_EN puts the first byte in the MSB lane
module tdec_wrap_lane_asm
    import tdec_wrap_out_packer_pkg::*;
#(
    parameter int OUT_BYTES = DEF_OUT_BYTES,
    parameter int LW        = $clog2(OUT_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic [8*OUT_BYTES-1:0] data,
    output logic [LW-1:0]          lane
);
    logic [LW-1:0] pos;
    // map the fill position to a physical lane
    always_comb begin
`ifdef TDEC_WRAP_PACKER_BSWAP_EN
        pos = LW'(OUT_BYTES - 1) - lane;
`else
        pos = lane;
`endif
    end
    // clear wins over a write; each write fills one lane and advances the counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            lane <= '0;
        end else if (clr) begin
            data <= '0;
            lane <= '0;
        end else if (wr_en) begin
            data[8*pos +: 8] <= wr_data;
            lane             <= lane + LW'(1);
        end
    end
endmodule

// File: rtl/tdec_wrap_out_packer.sv
// tdec_wrap_out_packer: pops FIFO bytes of one block and packs them into valid/ready words; byte order set by TDEC_WRAP_PACKER_BSWAP_EN
module tdec_wrap_out_packer
    import tdec_wrap_out_packer_pkg::*;
#(
    parameter int OUT_BYTES = DEF_OUT_BYTES,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       frame_len,
    input  logic                   abort,
    input  logic                   fifo_empty,
    input  logic [7:0]             fifo_rd_data,
    output logic                   fifo_rd_en,
    output logic                   fifo_flush,
    output logic                   out_valid,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);
    localparam int LW = $clog2(OUT_BYTES + 1);
    pack_state_t      state;
    logic [LEN_W-1:0] remaining;
    logic [LW-1:0]    lane;
    logic             lane_clr;
    logic             hs;
    assign out_valid  = state == PRESENT;
    assign busy       = state == FILL || state == PRESENT;
    assign hs         = out_valid && out_ready;
    assign fifo_rd_en = state == FILL && !abort && !fifo_empty && remaining != '0 && lane < LW'(OUT_BYTES);
    assign lane_clr   = abort || (state == IDLE && start) || hs;
    tdec_wrap_lane_asm #(.OUT_BYTES(OUT_BYTES), .LW(LW)) u_lane_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (lane_clr),
        .wr_en   (fifo_rd_en),
        .wr_data (fifo_rd_data),
        .data    (out_data),
        .lane    (lane)
    );
    // block sequencing: abort first, then fill / present / done with the remaining-byte countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            fifo_flush <= 1'b0;
        end else begin
            done       <= 1'b0;
            fifo_flush <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                remaining  <= '0;
                out_last   <= 1'b0;
                fifo_flush <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        if (frame_len != '0) begin
                            remaining <= frame_len;
                            state     <= FILL;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    FILL: if (fifo_rd_en) begin
                        remaining <= remaining - LEN_W'(1);
                        if (lane == LW'(OUT_BYTES - 1) || remaining == LEN_W'(1)) begin
                            state    <= PRESENT;
                            out_last <= remaining == LEN_W'(1);
                        end
                    end
                    PRESENT: if (out_ready) begin
                        state    <= out_last ? DONE : FILL;
                        done     <= out_last;
                        out_last <= 1'b0;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdec_wrap_out_packer.sv
// tb_tdec_wrap_out_packer: directed and random blocks checked against a byte-list packing model
module tb_tdec_wrap_out_packer;
    localparam int OB = 4;
    localparam int DW = 8 * OB;
    logic          clk = 1'b0;
    logic          rst, start, abort, out_ready;
    logic [15:0]   frame_len;
    logic          fifo_empty, fifo_rd_en, fifo_flush;
    logic [7:0]    fifo_rd_data;
    logic          out_valid, out_last, busy, done;
    logic [DW-1:0] out_data;
    logic [7:0]    mem [0:4095];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          gate = 1'b0;
    logic          drop = 1'b0;
    int            pops = 0, dones = 0, flushes = 0, vcyc = 0, bad_pops = 0;
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    int            compared = 0, mismatched = 0;

    tdec_wrap_out_packer dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .abort(abort),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .fifo_flush(fifo_flush), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign fifo_empty   = (rd_ptr == wr_ptr) || gate;
    assign fifo_rd_data = mem[rd_ptr];

    // FIFO model and event monitors
    always @(posedge clk) begin
        if (fifo_flush || drop) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
        if (fifo_rd_en) pops <= pops + 1;
        if (fifo_rd_en && fifo_empty) bad_pops <= bad_pops + 1;
        if (done) dones <= dones + 1;
        if (fifo_flush) flushes <= flushes + 1;
        if (out_valid) vcyc <= vcyc + 1;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    // expected words of a block: byte i lands in word i/OB at lane i%OB (mirrored when swapped)
    task automatic model(input int base, input int len, output logic [DW-1:0] w [$], output logic l [$]);
        int nw;
        nw = (len + OB - 1) / OB;
        w = {};
        l = {};
        for (int k = 0; k < nw; k++) begin
            w.push_back('0);
            l.push_back(k == nw - 1);
        end
        for (int i = 0; i < len; i++) begin
`ifdef TDEC_WRAP_PACKER_BSWAP_EN
            w[i / OB] = w[i / OB] | (DW'(mem[base + i]) << (8 * (OB - 1 - i % OB)));
`else
            w[i / OB] = w[i / OB] | (DW'(mem[base + i]) << (8 * (i % OB)));
`endif
        end
    endtask

    // emode: 0 never empty, 1 random empty, 2 empty every other cycle
    task automatic run_block(input string tag, input int base, input int len, input bit rnd_ready,
                             input int emode, input bit restart);
        logic [DW-1:0] ew [$];
        logic          el [$];
        int p0, d0, g0, n;
        model(base, len, ew, el);
        p0 = pops;
        d0 = dones;
        g0 = got_d.size();
        n  = 0;
        @(negedge clk);
        start     = 1'b1;
        frame_len = 16'(len);
        @(negedge clk);
        start = 1'b0;
        while (dones == d0 && n < 2000) begin
            out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            gate      = emode == 1 ? 1'($urandom % 2) : emode == 2 ? ~gate : 1'b0;
            if (restart && n == 1) begin
                start     = 1'b1;
                frame_len = 16'(len + 4);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start     = 1'b0;
        gate      = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_done_seen"}, 64'(dones != d0), 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_count"}, 64'(dones - d0), 64'd1);
        chk({tag, "_pops"}, 64'(pops - p0), 64'(len));
        chk({tag, "_words"}, 64'(got_d.size() - g0), 64'(ew.size()));
        for (int k = 0; k < ew.size() && g0 + k < got_d.size(); k++) begin
            chk({tag, "_data"}, 64'(got_d[g0 + k]), 64'(ew[k]));
            chk({tag, "_last"}, 64'(got_l[g0 + k]), 64'(el[k]));
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int base, p0, d0, f0, v0, n;
        logic [DW-1:0] held;
        logic [DW-1:0] ew [$];
        logic          el [$];
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; frame_len = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({fifo_rd_en, fifo_flush, out_valid, out_last, busy, done}), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        base = wr_ptr;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        run_block("len8", base, 8, 1'b0, 0, 1'b0);
`ifdef TDEC_WRAP_PACKER_BSWAP_EN
        chk("len8_const", 64'(got_d[0]), 64'h01020304);
`else
        chk("len8_const", 64'(got_d[0]), 64'h04030201);
`endif

        base = wr_ptr;
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD); push_byte(8'hEE);
        run_block("len5", base, 5, 1'b0, 0, 1'b0);
`ifdef TDEC_WRAP_PACKER_BSWAP_EN
        chk("len5_pad", 64'(got_d[got_d.size() - 1]), 64'hEE000000);
`else
        chk("len5_pad", 64'(got_d[got_d.size() - 1]), 64'h000000EE);
`endif

        base = wr_ptr;
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        model(base, 4, ew, el);
        d0 = dones;
        out_ready = 1'b0;
        start = 1'b1; frame_len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("hold_valid_seen", 64'(out_valid), 64'd1);
        held = out_data;
        chk("hold_word", 64'(held), 64'(ew[0]));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_stable", 64'({out_valid, out_data, fifo_rd_en, fifo_empty}), 64'({1'b1, held, 1'b0, 1'b0}));
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("hold_done", 64'(dones - d0), 64'd1);
        drop = 1'b1;
        @(negedge clk);
        drop = 1'b0;

        base = wr_ptr;
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        run_block("toggle6", base, 6, 1'b0, 2, 1'b0);
        chk("toggle6_bad_pops", 64'(bad_pops), 64'd0);

        base = wr_ptr;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        p0 = pops; d0 = dones; f0 = flushes; v0 = vcyc;
        start = 1'b1; frame_len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (pops - p0 < 2 && n < 50) begin @(negedge clk); n++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pops", 64'(pops - p0), 64'd2);
        chk("abort_flush", 64'(flushes - f0), 64'd1);
        chk("abort_no_valid", 64'(vcyc - v0), 64'd0);
        chk("abort_no_done", 64'(dones - d0), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        base = wr_ptr;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        run_block("after_abort", base, 4, 1'b0, 0, 1'b0);

        p0 = pops; v0 = vcyc; d0 = dones;
        start = 1'b1; frame_len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", 64'({done, busy}), 64'b10);
        @(negedge clk);
        chk("zero_done_once", 64'(done), 64'd0);
        chk("zero_no_output", 64'({32'(pops - p0), 32'(vcyc - v0)}), 64'd0);

        base = wr_ptr;
        for (int i = 0; i < 8; i++) push_byte(8'($urandom));
        run_block("restart_ignored", base, 4, 1'b0, 0, 1'b1);
        drop = 1'b1;
        @(negedge clk);
        drop = 1'b0;

        for (int t = 0; t < 8; t++) begin
            int len;
            len  = 1 + int'($urandom % 11);
            base = wr_ptr;
            for (int i = 0; i < len; i++) push_byte(8'($urandom));
            run_block("random", base, len, 1'b1, 1, 1'b0);
        end
        chk("bad_pops_total", 64'(bad_pops), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
